// File: rtl/pixel_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pixel_writer                                                 |
// | Description : Avalon-MM write master filling a framebuffer with an         |
// |               animated RGB565 raster test pattern, one pixel per transfer. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module pixel_writer #(
    parameter int          WIDTH     = 640,
    parameter int          HEIGHT    = 480,
    parameter logic [19:0] BASE_ADDR = 20'h00000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [19:0] mm_address,
    output logic        mm_write,
    output logic [15:0] mm_writedata,
    input  logic        mm_waitrequest
);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_write = 1'b1;

    localparam logic [9:0] c_x_last = 10'(WIDTH - 1);
    localparam logic [9:0] c_y_last = 10'(HEIGHT - 1);

    logic [0:0]  r_state;
    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic [7:0]  r_f;
    logic [19:0] r_addr;
    logic        r_write;
    logic [15:0] r_data;

    logic        w_x_wrap;
    logic        w_y_wrap;
    logic [9:0]  w_next_x;
    logic [9:0]  w_next_y;
    logic [7:0]  w_next_f;
    logic [19:0] w_next_addr;

    // Successor of the pixel currently on the bus, in raster order.
    always_comb begin
        w_x_wrap    = (r_x == c_x_last);
        w_y_wrap    = (r_y == c_y_last);
        w_next_x    = r_x + 10'd1;
        w_next_y    = r_y;
        w_next_f    = r_f;
        w_next_addr = r_addr + 20'd1;
        if (w_x_wrap) begin
            w_next_x = 10'd0;
            w_next_y = r_y + 10'd1;
            if (w_y_wrap) begin
                w_next_y    = 10'd0;
                w_next_f    = r_f + 8'd1;
                w_next_addr = BASE_ADDR;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_idle;
            r_x     <= 10'd0;
            r_y     <= 10'd0;
            r_f     <= 8'd0;
            r_addr  <= BASE_ADDR;
            r_write <= 1'b0;
            r_data  <= 16'h0000;
        end else begin
            case (r_state)
                c_idle: begin
                    r_state <= c_write;
                    r_write <= 1'b1;
                end
                c_write: begin
                    // Everything holds while the slave stalls.
                    if (!mm_waitrequest) begin
                        r_x    <= w_next_x;
                        r_y    <= w_next_y;
                        r_f    <= w_next_f;
                        r_addr <= w_next_addr;
                        r_data <= {w_next_x[4:0], w_next_y[5:0], w_next_f[4:0]};
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_write <= 1'b0;
                end
            endcase
        end
    end

    assign mm_address   = r_addr;
    assign mm_write     = r_write;
    assign mm_writedata = r_data;

endmodule
`default_nettype wire

// File: tb/tb_pixel_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pixel_writer                                              |
// | Description : Directed self-checking bench for pixel_writer.               |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_pixel_writer;

    logic        clk;
    logic        rst_n_a, wait_a, wr_a;
    logic [19:0] addr_a;
    logic [15:0] data_a;
    logic        rst_n_b, wait_b, wr_b;
    logic [19:0] addr_b;
    logic [15:0] data_b;

    int total = 0;
    int bad   = 0;

    // Default 640x480 frame at address 0.
    pixel_writer u_dut_a (
        .clk            (clk),
        .reset_n        (rst_n_a),
        .mm_address     (addr_a),
        .mm_write       (wr_a),
        .mm_writedata   (data_a),
        .mm_waitrequest (wait_a)
    );

    // Small 40x70 frame at a non-zero base so frame wraps fit in the run.
    pixel_writer #(
        .WIDTH     (40),
        .HEIGHT    (70),
        .BASE_ADDR (20'h10000)
    ) u_dut_b (
        .clk            (clk),
        .reset_n        (rst_n_b),
        .mm_address     (addr_b),
        .mm_write       (wr_b),
        .mm_writedata   (data_b),
        .mm_waitrequest (wait_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n_a = 1'b0;
        wait_a  = 1'b0;
        step();
        total++;
        if ({wr_a, addr_a, data_a} !== {1'b0, 20'h00000, 16'h0000}) begin
            bad++;
            $display("FAIL reset_hold: got w=%b a=%h d=%h want w=0 a=00000 d=0000", wr_a, addr_a, data_a);
        end
        rst_n_a = 1'b1;
        step();
        total++;
        if ({wr_a, addr_a, data_a} !== {1'b1, 20'h00000, 16'h0000}) begin
            bad++;
            $display("FAIL first_write: got w=%b a=%h d=%h want w=1 a=00000 d=0000", wr_a, addr_a, data_a);
        end
    endtask

    task automatic test_streaming;
        logic [19:0] exp_a [2] = '{20'h00001, 20'h00002};
        logic [15:0] exp_d [2] = '{16'h0800, 16'h1000};
        wait_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({wr_a, addr_a, data_a} !== {1'b1, exp_a[i], exp_d[i]}) begin
                bad++;
                $display("FAIL stream_%0d: got w=%b a=%h d=%h want w=1 a=%h d=%h", i, wr_a, addr_a, data_a, exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_stall;
        logic [19:0] exp_a [4] = '{20'h00003, 20'h00004, 20'h00005, 20'h00006};
        logic [15:0] exp_d [4] = '{16'h1800, 16'h2000, 16'h2800, 16'h3000};
        wait_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({wr_a, addr_a, data_a} !== {1'b1, 20'h00002, 16'h1000}) begin
                bad++;
                $display("FAIL stall_hold_%0d: got w=%b a=%h d=%h want w=1 a=00002 d=1000", i, wr_a, addr_a, data_a);
            end
        end
        wait_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if ({wr_a, addr_a, data_a} !== {1'b1, exp_a[i], exp_d[i]}) begin
                bad++;
                $display("FAIL stall_resume_%0d: got w=%b a=%h d=%h want w=1 a=%h d=%h", i, wr_a, addr_a, data_a, exp_a[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_line_wrap;
        // Six pixels already accepted; 634 more completes line 0.
        wait_a = 1'b0;
        repeat (633) step();
        total++;
        if ({addr_a, data_a} !== {20'h0027F, 16'hF800}) begin
            bad++;
            $display("FAIL line_last: got a=%h d=%h want a=0027F d=f800", addr_a, data_a);
        end
        step();
        total++;
        if ({wr_a, addr_a, data_a} !== {1'b1, 20'h00280, 16'h0020}) begin
            bad++;
            $display("FAIL line_wrap: got w=%b a=%h d=%h want w=1 a=00280 d=0020", wr_a, addr_a, data_a);
        end
    endtask

    task automatic test_async_reset;
        wait_a = 1'b1;
        step();
        #2;
        rst_n_a = 1'b0;
        #1;
        total++;
        if ({wr_a, addr_a, data_a} !== {1'b0, 20'h00000, 16'h0000}) begin
            bad++;
            $display("FAIL async_reset: got w=%b a=%h d=%h want w=0 a=00000 d=0000", wr_a, addr_a, data_a);
        end
        step();
        rst_n_a = 1'b1;
        wait_a  = 1'b0;
        step();
        total++;
        if ({wr_a, addr_a, data_a} !== {1'b1, 20'h00000, 16'h0000}) begin
            bad++;
            $display("FAIL restart_first: got w=%b a=%h d=%h want w=1 a=00000 d=0000", wr_a, addr_a, data_a);
        end
        step();
        total++;
        if ({wr_a, addr_a, data_a} !== {1'b1, 20'h00001, 16'h0800}) begin
            bad++;
            $display("FAIL restart_second: got w=%b a=%h d=%h want w=1 a=00001 d=0800", wr_a, addr_a, data_a);
        end
    endtask

    task automatic test_frame_wrap;
        rst_n_b = 1'b0;
        wait_b  = 1'b0;
        step();
        total++;
        if ({wr_b, addr_b, data_b} !== {1'b0, 20'h10000, 16'h0000}) begin
            bad++;
            $display("FAIL b_reset: got w=%b a=%h d=%h want w=0 a=10000 d=0000", wr_b, addr_b, data_b);
        end
        rst_n_b = 1'b1;
        step();
        // 40 accepts finish line 0 of the small frame.
        repeat (40) step();
        total++;
        if ({addr_b, data_b} !== {20'h10028, 16'h0020}) begin
            bad++;
            $display("FAIL b_line_wrap: got a=%h d=%h want a=10028 d=0020", addr_b, data_b);
        end
        // Last pixel (39,69): r=7, g=5, f=0; address base+2799.
        repeat (2759) step();
        total++;
        if ({wr_b, addr_b, data_b} !== {1'b1, 20'h10AEF, 16'h38A0}) begin
            bad++;
            $display("FAIL frame_last: got w=%b a=%h d=%h want w=1 a=10aef d=38a0", wr_b, addr_b, data_b);
        end
        wait_b = 1'b1;
        step();
        total++;
        if ({wr_b, addr_b, data_b} !== {1'b1, 20'h10AEF, 16'h38A0}) begin
            bad++;
            $display("FAIL frame_last_stall: got w=%b a=%h d=%h want w=1 a=10aef d=38a0", wr_b, addr_b, data_b);
        end
        wait_b = 1'b0;
        step();
        total++;
        if ({wr_b, addr_b, data_b} !== {1'b1, 20'h10000, 16'h0001}) begin
            bad++;
            $display("FAIL frame_wrap: got w=%b a=%h d=%h want w=1 a=10000 d=0001", wr_b, addr_b, data_b);
        end
        step();
        total++;
        if ({wr_b, addr_b, data_b} !== {1'b1, 20'h10001, 16'h0801}) begin
            bad++;
            $display("FAIL frame1_second: got w=%b a=%h d=%h want w=1 a=10001 d=0801", wr_b, addr_b, data_b);
        end
    endtask

    task automatic test_frame_reset;
        // Reset during a stall must also clear the frame counter.
        wait_b = 1'b1;
        step();
        #3;
        rst_n_b = 1'b0;
        #1;
        total++;
        if ({wr_b, addr_b, data_b} !== {1'b0, 20'h10000, 16'h0000}) begin
            bad++;
            $display("FAIL b_async_reset: got w=%b a=%h d=%h want w=0 a=10000 d=0000", wr_b, addr_b, data_b);
        end
        step();
        rst_n_b = 1'b1;
        wait_b  = 1'b0;
        step();
        step();
        total++;
        if ({wr_b, addr_b, data_b} !== {1'b1, 20'h10001, 16'h0800}) begin
            bad++;
            $display("FAIL b_restart_f0: got w=%b a=%h d=%h want w=1 a=10001 d=0800", wr_b, addr_b, data_b);
        end
    endtask

    initial begin
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        wait_a  = 1'b0;
        wait_b  = 1'b0;
        #2;
        test_reset();
        test_streaming();
        test_stall();
        test_line_wrap();
        test_async_reset();
        test_frame_wrap();
        test_frame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
